// File: rtl/display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_ctrl
//  Purpose  : Clock display mode controller. Selects time or alarm view,
//             walks the hour/minute/second edit fields, issues one-cycle
//             increment pulses and drives the edit-field blink phase.
//  Options  : define DISPLAY_CTRL_TIMEOUT_EN to add the key-inactivity
//             auto-return to time display after TIMEOUT_SEC seconds.
//  Revision : 1.0 - initial release
// ============================================================================
module display_ctrl #(
  parameter int TIMEOUT_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_next,
  input  logic       key_inc,
  output logic       sel,
  output logic [1:0] field,
  output logic       inc_time,
  output logic       inc_alarm,
  output logic       blank
);

  // Encoding chosen so bit 0 marks a SET state and bit 1 marks the alarm view.
  typedef enum logic [1:0] {
    TIME_SHOW  = 2'b00,
    TIME_SET   = 2'b01,
    ALARM_SHOW = 2'b10,
    ALARM_SET  = 2'b11
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  // Reject an out-of-range timeout at elaboration rather than wrap silently.
  if (TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63) begin : g_timeout_sec_check
    $error("display_ctrl: TIMEOUT_SEC must be in 1..63");
  end

  state_t     state_q, state_d;
  logic       sel_q, sel_d;
  logic [1:0] field_q, field_d;
  logic       inc_time_q, inc_time_d;
  logic       inc_alarm_q, inc_alarm_d;
  logic       blank_q, blank_d;
  logic       key_any;
  logic       in_set;
  logic       next_is_show;

`ifdef DISPLAY_CTRL_TIMEOUT_EN
  localparam logic [5:0] TIMEOUT_LIM = 6'(TIMEOUT_SEC);
  logic [5:0] cnt_q, cnt_d;
`endif

  assign key_any = key_mode | key_next | key_inc;
  assign in_set  = state_q[0];

  // Next-state, field, pulse and blink computation; key_mode > key_next > key_inc.
  always_comb begin
    state_d      = state_q;
    field_d      = field_q;
    inc_time_d   = 1'b0;
    inc_alarm_d  = 1'b0;
    blank_d      = blank_q;
    next_is_show = 1'b0;
`ifdef DISPLAY_CTRL_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif

    if (key_mode) begin
      case (state_q)
        TIME_SHOW:  state_d = ALARM_SHOW;
        ALARM_SHOW: state_d = TIME_SHOW;
        default: begin
          // Any edit in progress is abandoned.
          state_d = TIME_SHOW;
          field_d = FIELD_NONE;
        end
      endcase
    end else if (key_next) begin
      case (state_q)
        TIME_SHOW: begin
          state_d = TIME_SET;
          field_d = FIELD_HOUR;
        end
        ALARM_SHOW: begin
          state_d = ALARM_SET;
          field_d = FIELD_HOUR;
        end
        TIME_SET: begin
          if (field_q == FIELD_SEC) begin
            state_d = TIME_SHOW;
            field_d = FIELD_NONE;
          end else begin
            field_d = field_q + 2'b01;
          end
        end
        default: begin
          if (field_q == FIELD_SEC) begin
            state_d = ALARM_SHOW;
            field_d = FIELD_NONE;
          end else begin
            field_d = field_q + 2'b01;
          end
        end
      endcase
    end else if (key_inc) begin
      inc_time_d  = (state_q == TIME_SET);
      inc_alarm_d = (state_q == ALARM_SET);
    end

    // A key press always reveals the field; otherwise blink on the second tick.
    if (key_any) begin
      blank_d = 1'b0;
    end else if (tick_1hz && in_set) begin
      blank_d = ~blank_q;
    end

`ifdef DISPLAY_CTRL_TIMEOUT_EN
    // Keys restart the inactivity window; the time view never counts.
    if (key_any) begin
      cnt_d = 6'd0;
    end else if (tick_1hz && (state_q != TIME_SHOW)) begin
      if (cnt_q + 6'd1 == TIMEOUT_LIM) begin
        state_d = TIME_SHOW;
        field_d = FIELD_NONE;
        cnt_d   = 6'd0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
    if (state_d == TIME_SHOW) begin
      cnt_d = 6'd0;
    end
`endif

    // SHOW states never display an edit field or a blanked digit.
    next_is_show = ~state_d[0];
    if (next_is_show) begin
      field_d = FIELD_NONE;
      blank_d = 1'b0;
    end

    sel_d = ~state_d[1];
  end

  // State and registered outputs; reset takes effect without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= TIME_SHOW;
      sel_q       <= 1'b1;
      field_q     <= FIELD_NONE;
      inc_time_q  <= 1'b0;
      inc_alarm_q <= 1'b0;
      blank_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      field_q     <= field_d;
      inc_time_q  <= inc_time_d;
      inc_alarm_q <= inc_alarm_d;
      blank_q     <= blank_d;
    end
  end

`ifdef DISPLAY_CTRL_TIMEOUT_EN
  // Seconds of key inactivity outside the time view.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign sel       = sel_q;
  assign field     = field_q;
  assign inc_time  = inc_time_q;
  assign inc_alarm = inc_alarm_q;
  assign blank     = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_ctrl
//  Purpose  : Directed self-checking bench for display_ctrl. A second
//             instance with TIMEOUT_SEC=3 exercises the inactivity timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_display_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0, key_mode = 1'b0, key_next = 1'b0, key_inc = 1'b0;
  logic       sel, inc_time, inc_alarm, blank;
  logic [1:0] field;

  logic       to_tick = 1'b0, to_mode = 1'b0, to_next = 1'b0, to_inc = 1'b0;
  logic       to_sel, to_inc_time, to_inc_alarm, to_blank;
  logic [1:0] to_field;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  display_ctrl #(.TIMEOUT_SEC(10)) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
    .sel(sel), .field(field), .inc_time(inc_time),
    .inc_alarm(inc_alarm), .blank(blank)
  );

  display_ctrl #(.TIMEOUT_SEC(3)) dut_to (
    .clk(clk), .reset(reset), .tick_1hz(to_tick),
    .key_mode(to_mode), .key_next(to_next), .key_inc(to_inc),
    .sel(to_sel), .field(to_field), .inc_time(to_inc_time),
    .inc_alarm(to_inc_alarm), .blank(to_blank)
  );

  // One clock of stimulus on the main instance; returns 1 ns after the edge.
  task automatic drive(input logic m, input logic n, input logic i, input logic t);
    @(negedge clk);
    key_mode = m; key_next = n; key_inc = i; tick_1hz = t;
    @(posedge clk);
    #1;
    key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  // One clock of stimulus on the timeout instance.
  task automatic drive_to(input logic m, input logic n, input logic i, input logic t);
    @(negedge clk);
    to_mode = m; to_next = n; to_inc = i; to_tick = t;
    @(posedge clk);
    #1;
    to_mode = 1'b0; to_next = 1'b0; to_inc = 1'b0; to_tick = 1'b0;
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({sel, field, inc_time, inc_alarm, blank} !== 6'b1_00_000) begin
      failures++;
      $display("FAIL reset_initial: got sel/field/inc_t/inc_a/blank=%b required 100000",
               {sel, field, inc_time, inc_alarm, blank});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    // Walk into ALARM_SET and leave an increment pulse on the output.
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    checks++;
    if (sel !== 1'b0 || field !== 2'b01) begin
      failures++;
      $display("FAIL reset_enter_alarm_set: got sel=%b field=%b required sel=0 field=01", sel, field);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (inc_alarm !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_pulse: got inc_alarm=%b required 1", inc_alarm);
    end
    // Asynchronous reset mid-edit, sampled before the next clock edge.
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({sel, field, inc_time, inc_alarm, blank} !== 6'b1_00_000) begin
      failures++;
      $display("FAIL reset_mid_edit: got sel/field/inc_t/inc_a/blank=%b required 100000",
               {sel, field, inc_time, inc_alarm, blank});
    end
    @(negedge clk) reset = 1'b0;
    drive(0, 0, 0, 0);
    checks++;
    if ({sel, field, inc_time, inc_alarm, blank} !== 6'b1_00_000) begin
      failures++;
      $display("FAIL reset_after_release: got sel/field/inc_t/inc_a/blank=%b required 100000",
               {sel, field, inc_time, inc_alarm, blank});
    end
  endtask

  task automatic test_view_toggle;
    drive(1, 0, 0, 0);
    checks++;
    if (sel !== 1'b0 || field !== 2'b00) begin
      failures++;
      $display("FAIL toggle_to_alarm: got sel=%b field=%b required sel=0 field=00", sel, field);
    end
    drive(1, 0, 0, 0);
    checks++;
    if (sel !== 1'b1 || field !== 2'b00) begin
      failures++;
      $display("FAIL toggle_to_time: got sel=%b field=%b required sel=1 field=00", sel, field);
    end
  endtask

  task automatic test_edit_walk;
    drive(0, 1, 0, 0);
    checks++;
    if (sel !== 1'b1 || field !== 2'b01) begin
      failures++;
      $display("FAIL walk_hour: got sel=%b field=%b required sel=1 field=01", sel, field);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (field !== 2'b10) begin
      failures++;
      $display("FAIL walk_minute: got field=%b required 10", field);
    end
    drive(0, 0, 1, 0);
    checks++;
    if (inc_time !== 1'b1 || inc_alarm !== 1'b0 || field !== 2'b10) begin
      failures++;
      $display("FAIL walk_inc_pulse: got inc_time=%b inc_alarm=%b field=%b required 1 0 10",
               inc_time, inc_alarm, field);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (inc_time !== 1'b0 || inc_alarm !== 1'b0) begin
      failures++;
      $display("FAIL walk_inc_single: got inc_time=%b inc_alarm=%b required 0 0", inc_time, inc_alarm);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (field !== 2'b11) begin
      failures++;
      $display("FAIL walk_second: got field=%b required 11", field);
    end
    drive(0, 1, 0, 0);
    checks++;
    if (sel !== 1'b1 || field !== 2'b00) begin
      failures++;
      $display("FAIL walk_exit: got sel=%b field=%b required sel=1 field=00", sel, field);
    end
    // From TIME_SHOW a mode key must reach the alarm view.
    drive(1, 0, 0, 0);
    checks++;
    if (sel !== 1'b0 || field !== 2'b00) begin
      failures++;
      $display("FAIL walk_state_is_show: got sel=%b field=%b required sel=0 field=00", sel, field);
    end
    drive(1, 0, 0, 0);
  endtask

  task automatic test_priority;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 1, 0);
    checks++;
    if (field !== 2'b10 || inc_alarm !== 1'b0 || sel !== 1'b0) begin
      failures++;
      $display("FAIL prio_next_over_inc: got field=%b inc_alarm=%b sel=%b required 10 0 0",
               field, inc_alarm, sel);
    end
    drive(1, 0, 1, 0);
    checks++;
    if (sel !== 1'b1 || field !== 2'b00 || inc_alarm !== 1'b0 || inc_time !== 1'b0) begin
      failures++;
      $display("FAIL prio_mode_over_inc: got sel=%b field=%b inc_alarm=%b inc_time=%b required 1 00 0 0",
               sel, field, inc_alarm, inc_time);
    end
    drive(0, 0, 0, 0);
    checks++;
    if (inc_alarm !== 1'b0 || inc_time !== 1'b0) begin
      failures++;
      $display("FAIL prio_no_late_pulse: got inc_alarm=%b inc_time=%b required 0 0", inc_alarm, inc_time);
    end
    drive(1, 1, 0, 0);
    checks++;
    if (sel !== 1'b0 || field !== 2'b00) begin
      failures++;
      $display("FAIL prio_mode_over_next: got sel=%b field=%b required sel=0 field=00", sel, field);
    end
    drive(1, 0, 0, 0);
  endtask

  task automatic test_blink;
    logic [3:0] exp_blank;
    exp_blank = 4'b1010;
    drive(0, 1, 0, 0);
    checks++;
    if (blank !== 1'b0) begin
      failures++;
      $display("FAIL blink_enter: got blank=%b required 0", blank);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 1);
      checks++;
      if (blank !== exp_blank[3-k]) begin
        failures++;
        $display("FAIL blink_tick%0d: got blank=%b required %b", k + 1, blank, exp_blank[3-k]);
      end
    end
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    checks++;
    if (blank !== 1'b0 || inc_time !== 1'b1) begin
      failures++;
      $display("FAIL blink_key_inc: got blank=%b inc_time=%b required 0 1", blank, inc_time);
    end
    drive(0, 0, 0, 1);
    drive(0, 1, 0, 1);
    checks++;
    if (blank !== 1'b0 || field !== 2'b10) begin
      failures++;
      $display("FAIL blink_key_with_tick: got blank=%b field=%b required 0 10", blank, field);
    end
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 1);
    checks++;
    if (blank !== 1'b0 || sel !== 1'b1 || field !== 2'b00) begin
      failures++;
      $display("FAIL blink_show_tick: got blank=%b sel=%b field=%b required 0 1 00", blank, sel, field);
    end
  endtask

  task automatic test_timeout;
`ifdef DISPLAY_CTRL_TIMEOUT_EN
    drive_to(1, 0, 0, 0);
    drive_to(0, 0, 0, 1);
    drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early: got sel=%b required 0 after 2 ticks", to_sel);
    end
    drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b1 || to_field !== 2'b00 || to_blank !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire: got sel=%b field=%b blank=%b required 1 00 0",
               to_sel, to_field, to_blank);
    end
    drive_to(1, 0, 0, 0);
    drive_to(0, 0, 0, 1);
    drive_to(0, 0, 0, 1);
    drive_to(0, 0, 1, 1);
    checks++;
    if (to_sel !== 1'b0) begin
      failures++;
      $display("FAIL timeout_key_wins: got sel=%b required 0", to_sel);
    end
    drive_to(0, 0, 0, 1);
    drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b0) begin
      failures++;
      $display("FAIL timeout_counter_cleared: got sel=%b required 0", to_sel);
    end
    drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b1) begin
      failures++;
      $display("FAIL timeout_refire: got sel=%b required 1", to_sel);
    end
    drive_to(1, 0, 0, 0);
    drive_to(0, 1, 0, 0);
    repeat (3) drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b1 || to_field !== 2'b00 || to_blank !== 1'b0) begin
      failures++;
      $display("FAIL timeout_from_set: got sel=%b field=%b blank=%b required 1 00 0",
               to_sel, to_field, to_blank);
    end
`else
    drive_to(1, 0, 0, 0);
    repeat (5) drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b0 || to_field !== 2'b00) begin
      failures++;
      $display("FAIL no_timeout_show: got sel=%b field=%b required 0 00", to_sel, to_field);
    end
    drive_to(0, 1, 0, 0);
    repeat (4) drive_to(0, 0, 0, 1);
    checks++;
    if (to_sel !== 1'b0 || to_field !== 2'b01 || to_blank !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout_set: got sel=%b field=%b blank=%b required 0 01 0",
               to_sel, to_field, to_blank);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_view_toggle();
    test_edit_walk();
    test_priority();
    test_blink();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/display_ctrl.md
DISPLAY_CTRL -- requirements
Module: display_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10, meaning seconds of key inactivity before auto-return to time display (legal 1..63).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick_1hz  input  1  one-clk-wide pulse once per second.
REQ-005 SHALL have port key_mode  input  1  debounced one-clk pulse: toggles time/alarm view.
REQ-006 SHALL have port key_next  input  1  debounced one-clk pulse: enter set / advance field / leave set.
REQ-007 SHALL have port key_inc  input  1  debounced one-clk pulse: increment selected field.
REQ-008 SHALL have port sel  output  1  bus selector control: 1 = timer/set register, 0 = alarm register.
REQ-009 SHALL have port field  output  2  field under edit: 00 none, 01 hour, 10 minute, 11 second.
REQ-010 SHALL have port inc_time  output  1  one-clk pulse: increment field of timer register.
REQ-011 SHALL have port inc_alarm  output  1  one-clk pulse: increment field of alarm register.
REQ-012 SHALL have port blank  output  1  1 = blank the edited field (blink phase).

Function
REQ-013 SHALL implement FSM states TIME_SHOW, TIME_SET, ALARM_SHOW, ALARM_SET; all outputs registered.
REQ-014 SHALL drive sel=1 in TIME_SHOW/TIME_SET and sel=0 in ALARM_SHOW/ALARM_SET.
REQ-015 SHALL, on key_mode: TIME_SHOW->ALARM_SHOW, ALARM_SHOW->TIME_SHOW; in any SET state abort to TIME_SHOW, field=00.
REQ-016 SHALL, on key_next in a SHOW state, enter the matching SET state with field=01.
REQ-017 SHALL, on key_next in a SET state, advance field 01->10->11; from 11 return to the matching SHOW state with field=00.
REQ-018 SHALL, on key_inc in TIME_SET, assert inc_time for exactly one clk on the following edge; in ALARM_SET likewise inc_alarm; ignore key_inc in SHOW states.
REQ-019 SHALL never assert inc_time and inc_alarm together; both 0 outside SET states.
REQ-020 SHALL give key priority key_mode > key_next > key_inc when pulses coincide; lower-priority keys in that cycle are discarded.
REQ-021 SHALL toggle blank on each tick_1hz while in a SET state, force blank=0 in SHOW states, and force blank=0 on any key pulse (field visible right after edit).
REQ-022 SHALL hold field=00 in SHOW states.

Reset
REQ-023 SHALL, while reset=1, immediately force state TIME_SHOW, sel=1, field=00, inc_time=0, inc_alarm=0, blank=0, inactivity counter=0, independent of clk.
REQ-024 SHALL, on reset asserted mid-edit, discard the edit in progress with no increment pulse emitted.

Configuration
REQ-025 SHALL, with macro DISPLAY_CTRL_TIMEOUT_EN defined, include a 6-bit inactivity counter: cleared on any key pulse or on entering TIME_SHOW, incremented on tick_1hz in TIME_SET/ALARM_SHOW/ALARM_SET; on reaching TIME_SEC -- specifically TIMEOUT_SEC -- go to TIME_SHOW, field=00, blank=0, counter=0.
REQ-026 SHALL, when a key pulse and the timeout-reaching tick coincide, let the key win and clear the counter.
REQ-027 SHALL, without DISPLAY_CTRL_TIMEOUT_EN, contain no counter; states persist until keys or reset.

Verification
REQ-028 SHALL test reset: assert reset mid-ALARM_SET -> sel=1, field=00, all pulses 0 without clk edge.
REQ-029 SHALL test view toggle: key_mode x2 from TIME_SHOW -> sel 1->0->1, field stays 00.
REQ-030 SHALL test edit walk: key_next x4 from TIME_SHOW -> field 01,10,11,00, state back to TIME_SHOW; key_inc at field 10 -> single inc_time pulse, inc_alarm=0.
REQ-031 SHALL test priority: key_mode+key_inc same cycle in ALARM_SET -> TIME_SHOW, no inc_alarm.
REQ-032 SHALL test timeout (macro on, TIMEOUT_SEC=3): ALARM_SHOW, 3 ticks no keys -> sel=1 after 3rd tick; key on 3rd tick -> stays ALARM_SHOW.
REQ-033 SHALL test blink: TIME_SET, 4 ticks -> blank 1,0,1,0; key_inc -> blank=0.
